// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared definitions for the retirement trace buffer.
// Holds the field widths, the packed trace entry layout and the push
// qualification rule used by wb_trace_buffer and wb_trace_fifo_mem.
package wb_trace_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned WE_W    = 4;
    localparam int unsigned WNUM_W  = 5;
    localparam int unsigned WDATA_W = 32;

    localparam int unsigned TRACE_ENTRY_W = PC_W + WE_W + WNUM_W + WDATA_W;  // 73

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [WE_W-1:0]    we;
        logic [WNUM_W-1:0]  wnum;
        logic [WDATA_W-1:0] wdata;
    } trace_entry_t;

    // A retirement is traced only if it really writes a non-zero register.
    function automatic logic entry_qualifies(input logic [WE_W-1:0]   we,
                                             input logic [WNUM_W-1:0] wnum);
        return (we != '0) && (wnum != '0);
    endfunction

endpackage

// File: rtl/wb_trace_fifo_mem.sv
// wb_trace_fifo_mem: storage array and read/write pointers of the trace FIFO.
// Ports:
//   i_clk, i_resetn  clock, asynchronous active-low reset (pointers only)
//   i_clear          synchronous flush of both pointers
//   i_push, i_entry  write i_entry at the tail (caller guarantees room)
//   i_pop            advance the head (caller guarantees non-empty)
//   o_head           entry at the head (undefined content while empty)
//   o_count          occupancy 0..DEPTH
//   o_empty, o_full  occupancy flags
module wb_trace_fifo_mem
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [TRACE_ENTRY_W-1:0] i_entry,
    input  logic                     i_pop,
    output logic [TRACE_ENTRY_W-1:0] o_head,
    output logic [AW:0]              o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [TRACE_ENTRY_W-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]              r_wptr;
    logic [AW:0]              r_rptr;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    // On push+pop while full the write lands in the slot being popped.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) r_mem[r_wptr[AW-1:0]] <= i_entry;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures register-writing retirements from the CPU debug
// write-back port into a FIFO and presents them on a valid/ready trace port.
// Optional feature macro: WB_TRACE_DROP_CNT_EN adds the trace_drop_cnt port.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   clear               synchronous flush (beats push and pop)
//   debug_wb_*          retiring pc / write mask / register / data
//   trace_valid/ready   head handshake, pop on valid && ready
//   trace_pc/we/wnum/wdata  head entry, zero while empty
//   trace_count         occupancy 0..DEPTH
//   trace_overflow      sticky, set when an entry was dropped
//   trace_drop_cnt      saturating dropped-entry count (macro only)
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic [31:0]   debug_wb_pc,
    input  logic [3:0]    debug_wb_rf_we,
    input  logic [4:0]    debug_wb_rf_wnum,
    input  logic [31:0]   debug_wb_rf_wdata,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [3:0]    trace_we,
    output logic [4:0]    trace_wnum,
    output logic [31:0]   trace_wdata,
    output logic [CW-1:0] trace_count,
    output logic          trace_overflow
`ifdef WB_TRACE_DROP_CNT_EN
    ,
    output logic [15:0]   trace_drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_entry_t w_entry;
    trace_entry_t w_head;
    trace_entry_t w_out;
    logic [AW:0]  w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_qualify;
    logic         w_pop;
    logic         w_push;
    logic         w_drop;
    logic         r_overflow;

    assign w_entry = '{pc:    debug_wb_pc,
                       we:    debug_wb_rf_we,
                       wnum:  debug_wb_rf_wnum,
                       wdata: debug_wb_rf_wdata};

    assign w_qualify = entry_qualifies(debug_wb_rf_we, debug_wb_rf_wnum);
    assign w_pop     = !w_empty && trace_ready;
    // A same-cycle pop frees the slot, so a full buffer can still accept.
    assign w_push    = w_qualify && (!w_full || w_pop);
    assign w_drop    = w_qualify && w_full && !w_pop;

    wb_trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_clear  (clear),
        .i_push   (w_push),
        .i_entry  (w_entry),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_empty  (w_empty),
        .o_full   (w_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign trace_drop_cnt = r_drop_cnt;
`endif

    // Storage is never reset, so mask the head whenever nothing is queued.
    assign w_out          = w_empty ? '0 : w_head;
    assign trace_valid    = !w_empty;
    assign trace_pc       = w_out.pc;
    assign trace_we       = w_out.we;
    assign trace_wnum     = w_out.wnum;
    assign trace_wdata    = w_out.wdata;
    assign trace_count    = CW'(w_count);
    assign trace_overflow = r_overflow;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: self-checking bench for wb_trace_buffer.
// A queue-based model tracks expected contents; a negedge process compares
// every output each cycle. Honours WB_TRACE_DROP_CNT_EN when defined.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear;
    logic [31:0]   pc;
    logic [3:0]    we;
    logic [4:0]    wnum;
    logic [31:0]   wdata;
    logic          ready;
    logic          trace_valid;
    logic [31:0]   trace_pc;
    logic [3:0]    trace_we;
    logic [4:0]    trace_wnum;
    logic [31:0]   trace_wdata;
    logic [CW-1:0] trace_count;
    logic          trace_overflow;
`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0]   trace_drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Behavioural model: queue of {pc, we, wnum, wdata}.
    logic [72:0] mq[$];
    bit          m_ovf;
    int          m_drop;
    logic [72:0] m_head;

    always #5 clk = ~clk;

    wb_trace_buffer #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .clear             (clear),
        .debug_wb_pc       (pc),
        .debug_wb_rf_we    (we),
        .debug_wb_rf_wnum  (wnum),
        .debug_wb_rf_wdata (wdata),
        .trace_valid       (trace_valid),
        .trace_ready       (ready),
        .trace_pc          (trace_pc),
        .trace_we          (trace_we),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .trace_count       (trace_count),
        .trace_overflow    (trace_overflow)
`ifdef WB_TRACE_DROP_CNT_EN
        ,
        .trace_drop_cnt    (trace_drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // One clock edge worth of specified behaviour, using the pre-edge state.
    task automatic model_step();
        bit qual;
        bit pop;
        bit was_full;
        qual     = (we != 4'h0) && (wnum != 5'd0);
        pop      = (mq.size() != 0) && ready;
        was_full = (mq.size() == DEPTH);
        if (clear) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (qual) begin
                if (!was_full || pop) begin
                    mq.push_back({pc, we, wnum, wdata});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            m_head = (mq.size() != 0) ? mq[0] : 73'd0;
            chk("count",    32'(trace_count),    32'(mq.size()));
            chk("valid",    32'(trace_valid),    32'(mq.size() != 0));
            chk("pc",       trace_pc,            m_head[72:41]);
            chk("we",       32'(trace_we),       32'(m_head[40:37]));
            chk("wnum",     32'(trace_wnum),     32'(m_head[36:32]));
            chk("wdata",    trace_wdata,         m_head[31:0]);
            chk("overflow", 32'(trace_overflow), 32'(m_ovf));
`ifdef WB_TRACE_DROP_CNT_EN
            chk("drop_cnt", 32'(trace_drop_cnt), 32'(m_drop));
`endif
        end
    end

    // Inputs change just after the negedge; the model follows each posedge.
    task automatic cyc();
        @(posedge clk);
        if (resetn) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] p, input logic [3:0] w,
                            input logic [4:0] n, input logic [31:0] d);
        pc = p; we = w; wnum = n; wdata = d;
    endtask

    task automatic idle();
        pc = '0; we = '0; wnum = '0; wdata = '0; clear = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        ready  = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count",    32'(trace_count),    32'd0);
        chk("rst_valid",    32'(trace_valid),    32'd0);
        chk("rst_pc",       trace_pc,            32'd0);
        chk("rst_overflow", 32'(trace_overflow), 32'd0);
        check_en = 1'b1;
        resetn   = 1'b1;
        cyc();

        // Single push into an empty buffer.
        set_push(32'h1c000000, 4'hF, 5'd4, 32'h12345678);
        cyc();
        idle();
        chk("p1_valid", 32'(trace_valid),  32'd1);
        chk("p1_pc",    trace_pc,          32'h1c000000);
        chk("p1_we",    32'(trace_we),     32'hF);
        chk("p1_wnum",  32'(trace_wnum),   32'd4);
        chk("p1_wdata", trace_wdata,       32'h12345678);
        chk("p1_count", 32'(trace_count),  32'd1);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        chk("p1_drain", 32'(trace_count),  32'd0);

        // Non-qualifying retirements.
        set_push(32'h40, 4'h0, 5'd5, 32'hAA);
        cyc();
        set_push(32'h44, 4'h3, 5'd0, 32'hBB);
        cyc();
        idle();
        chk("nq_count", 32'(trace_count), 32'd0);
        chk("nq_valid", 32'(trace_valid), 32'd0);

        // Fill past capacity: two drops.
        for (int i = 0; i < 18; i++) begin
            set_push(32'h1000 + 32'(4 * i), 4'hF, 5'(i % 31 + 1), 32'hC0DE0000 + 32'(i));
            cyc();
        end
        idle();
        chk("full_count", 32'(trace_count),    32'd16);
        chk("full_ovf",   32'(trace_overflow), 32'd1);
        chk("full_head",  trace_pc,            32'h1000);
`ifdef WB_TRACE_DROP_CNT_EN
        chk("full_drops", 32'(trace_drop_cnt), 32'd2);
`endif

        // Push and pop together while full.
        set_push(32'h2000, 4'h1, 5'd9, 32'h17);
        ready = 1'b1;
        cyc();
        idle();
        ready = 1'b0;
        chk("pp_count", 32'(trace_count), 32'd16);
        chk("pp_head",  trace_pc,         32'h1004);
`ifdef WB_TRACE_DROP_CNT_EN
        chk("pp_drops", 32'(trace_drop_cnt), 32'd2);
`endif

        // Drain to five entries, then clear against a push and pop.
        ready = 1'b1;
        repeat (11) cyc();
        ready = 1'b0;
        chk("five_count", 32'(trace_count),    32'd5);
        chk("five_head",  trace_pc,            32'h1030);
        chk("five_ovf",   32'(trace_overflow), 32'd1);
        set_push(32'h2100, 4'hF, 5'd3, 32'h5);
        clear = 1'b1;
        ready = 1'b1;
        cyc();
        idle();
        ready = 1'b0;
        chk("clr_count", 32'(trace_count),    32'd0);
        chk("clr_valid", 32'(trace_valid),    32'd0);
        chk("clr_ovf",   32'(trace_overflow), 32'd0);

        // Random traffic: congested phase, then a draining phase.
        for (int i = 0; i < 600; i++) begin
            pc    = $urandom;
            we    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            wnum  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            clear = ($urandom_range(0, 99) == 0);
            ready = ($urandom_range(0, 99) < ((i < 300) ? 25 : 70));
            cyc();
        end
        idle();
        ready = 1'b0;

        // Asynchronous reset mid-stream with seven entries queued.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_push(32'h5000 + 32'(4 * i), 4'h2, 5'd7, 32'(i));
            cyc();
        end
        idle();
        ready = 1'b1;
        repeat (9) cyc();
        ready = 1'b0;
        chk("pre_rst_count", 32'(trace_count),    32'd7);
        chk("pre_rst_ovf",   32'(trace_overflow), 32'd1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("ar_count", 32'(trace_count),    32'd0);
        chk("ar_valid", 32'(trace_valid),    32'd0);
        chk("ar_pc",    trace_pc,            32'd0);
        chk("ar_we",    32'(trace_we),       32'd0);
        chk("ar_wnum",  32'(trace_wnum),     32'd0);
        chk("ar_wdata", trace_wdata,         32'd0);
        chk("ar_ovf",   32'(trace_overflow), 32'd0);
`ifdef WB_TRACE_DROP_CNT_EN
        chk("ar_drops", 32'(trace_drop_cnt), 32'd0);
`endif
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(32'h3000 + 32'(4 * i), 4'hF, 5'(i + 1), 32'hD0 + 32'(i));
            cyc();
        end
        idle();
        chk("post_count", 32'(trace_count), 32'd3);
        chk("post_head0", trace_pc,         32'h3000);
        ready = 1'b1;
        cyc();
        chk("post_head1", trace_pc,         32'h3004);
        cyc();
        chk("post_head2", trace_pc,         32'h3008);
        cyc();
        ready = 1'b0;
        chk("post_empty", 32'(trace_valid), 32'd0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, >=2).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, width of trace_count.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- debug_wb_pc  in  32  retiring PC from the CPU trace port.
- debug_wb_rf_we  in  4  retiring write-enable byte mask.
- debug_wb_rf_wnum  in  5  retiring destination register.
- debug_wb_rf_wdata  in  32  retiring write data.
- trace_valid  out  1  head entry valid.
- trace_ready  in  1  consumer accepts head.
- trace_pc  out  32  head PC.
- trace_we  out  4  head write mask.
- trace_wnum  out  5  head register.
- trace_wdata  out  32  head data.
- trace_count  out  CW  occupied entries, 0..DEPTH.
- trace_overflow  out  1  sticky, an entry was dropped.
- trace_drop_cnt  out  16  dropped-entry count (present only with macro, REQ-020).

Function
REQ-004 SHALL qualify a push when debug_wb_rf_we != 4'h0 and debug_wb_rf_wnum != 5'd0; all other cycles are ignored.
REQ-005 SHALL store entry {pc, we, wnum, wdata} (73 bits) in arrival order; FIFO, no reordering.
REQ-006 SHALL pop on trace_valid && trace_ready; head advances at that clock edge.
REQ-007 SHALL present a pushed entry on trace_* exactly one cycle after the push edge when the buffer was empty (no same-cycle bypass).
REQ-008 SHALL hold trace_* stable while trace_valid && !trace_ready.
REQ-009 SHALL drive trace_valid = (trace_count != 0).
REQ-010 SHALL accept push and pop in the same cycle at any occupancy, including full; trace_count unchanged.
REQ-011 SHALL, on push when full without a same-cycle pop, drop the new entry, set trace_overflow, leave contents unchanged.
REQ-012 SHALL wrap read/write pointers modulo DEPTH; full/empty distinguished by the extra pointer bit.
REQ-013 SHALL, on clear, empty the buffer and zero trace_overflow (and trace_drop_cnt) at the next edge; clear overrides a same-cycle push and pop.
REQ-014 SHALL keep trace_overflow set until clear or reset.

Reset
REQ-015 SHALL, while resetn is low, asynchronously force trace_count=0, trace_valid=0, trace_overflow=0, trace_drop_cnt=0, pointers=0.
REQ-016 SHALL drive trace_pc/we/wnum/wdata = 0 while empty, including in reset.
REQ-017 SHALL discard all entries when reset asserts mid-operation; storage contents need not be cleared.
REQ-018 SHALL resume pushing on the first rising edge after resetn deasserts.

Configuration
REQ-019 SHALL use macro WB_TRACE_DROP_CNT_EN.
REQ-020 With WB_TRACE_DROP_CNT_EN defined: trace_drop_cnt port exists, increments by 1 per dropped entry, saturates at 16'hFFFF.
REQ-021 Without it: trace_drop_cnt port and counter absent; trace_overflow behaviour unchanged.

Structure
REQ-022 SHALL place TRACE_ENTRY_W=73, field widths and the entry struct in shared package wb_trace_pkg.
REQ-023 SHALL implement storage and pointers in sub-module wb_trace_fifo_mem; qualification, overflow and drop counter stay in wb_trace_buffer.

Verification
REQ-024 Push pc=0x1c000000, we=0xF, wnum=4, wdata=0x12345678 into empty buffer -> trace_valid=1 next cycle with those values, trace_count=1.
REQ-025 Pushes with we=0 or wnum=0 -> trace_count stays 0, trace_valid=0.
REQ-026 DEPTH=16, trace_ready=0, 18 qualified pushes -> trace_count=16, trace_overflow=1, trace_drop_cnt=2, head still first entry.
REQ-027 Full buffer, push and pop same cycle -> trace_count stays 16, entry 17 appended, no drop.
REQ-028 Assert clear together with a push while trace_count=5 -> trace_count=0, trace_valid=0, trace_overflow=0 next cycle.
REQ-029 Drop resetn low mid-stream with trace_count=7 -> all outputs 0 immediately; first push after release read back in order.
